// File: rtl/support_context_scheduler.sv
// Context-switch sequencer for the support unit array and boundary PEs: drives the global
// stage, tracks the resident context and the context window mirrored in PE memory.
module support_context_scheduler #(
  parameter int NUM_CONTEXTS = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 new_block,
  input  logic                                 req_valid,
  input  logic                                 req_local,
  output logic                                 req_ready,
  output logic [1:0]                           stage_out,
  output logic                                 do_not_store,
  output logic [$clog2(NUM_CONTEXTS)-1:0]      active_context,
  output logic [$clog2(NUM_CONTEXTS)-1:0]      context_min,
  output logic [$clog2(NUM_CONTEXTS)-1:0]      context_max,
  output logic                                 busy
);

  localparam int CTX_W       = $clog2(NUM_CONTEXTS);
  localparam int HALF        = NUM_CONTEXTS / 2;
  localparam int STAGE_WIDTH = 2;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE         = 2'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESET_ROOTS  = 2'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM = 2'd2;

  localparam logic [CTX_W-1:0] CTX_ZERO    = '0;
  localparam logic [CTX_W-1:0] CTX_ONE     = CTX_W'(1);
  localparam logic [CTX_W-1:0] CTX_HALF    = CTX_W'(HALF);
  localparam logic [CTX_W-1:0] CTX_HALF_M1 = CTX_W'(HALF - 1);
  localparam logic [CTX_W-1:0] CTX_LAST    = CTX_W'(NUM_CONTEXTS - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_RESET_ROOTS = 2'd1,
    S_WRITE       = 2'd2,
    S_SETTLE      = 2'd3
  } state_t;

  // Handshake: a switch is taken on a clock edge where req_valid && req_ready; the requester
  // holds req_valid/req_local stable until then. req_ready drops while a root reset is due.

  state_t                 state_q, state_d;
  logic [STAGE_WIDTH-1:0] stage_q, stage_d;
  logic                   busy_q, busy_d;
  logic                   dns_q, dns_d;
  logic                   pending_q, pending_d;
  logic                   full_range_q, full_range_d;
  logic                   not_first_q, not_first_d;
  logic [CTX_W-1:0]       ctx_q, ctx_d;
  logic [CTX_W-1:0]       min_q, min_d;
  logic [CTX_W-1:0]       max_q, max_d;
  logic                   accept;

  assign req_ready      = (state_q == S_IDLE) && !new_block && !pending_q;
  assign accept         = req_valid && req_ready;
  assign stage_out      = stage_q;
  assign busy           = busy_q;
  assign do_not_store   = dns_q;
  assign active_context = ctx_q;
  assign context_min    = min_q;
  assign context_max    = max_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      stage_q      <= STAGE_IDLE;
      busy_q       <= 1'b0;
      dns_q        <= 1'b0;
      pending_q    <= 1'b0;
      full_range_q <= 1'b0;
      not_first_q  <= 1'b0;
      ctx_q        <= CTX_ZERO;
      min_q        <= CTX_ZERO;
      max_q        <= CTX_HALF_M1;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      busy_q       <= busy_d;
      dns_q        <= dns_d;
      pending_q    <= pending_d;
      full_range_q <= full_range_d;
      not_first_q  <= not_first_d;
      ctx_q        <= ctx_d;
      min_q        <= min_d;
      max_q        <= max_d;
    end
  end

  // Next-state and context bookkeeping.
  always_comb begin
    state_d      = state_q;
    dns_d        = dns_q;
    pending_d    = pending_q;
    full_range_d = full_range_q;
    not_first_d  = not_first_q;
    ctx_d        = ctx_q;
    min_d        = min_q;
    max_d        = max_q;

    if (accept) begin
      dns_d = req_local;
    end

    case (state_q)
      S_IDLE: begin
        pending_d = 1'b0;
        if (new_block || pending_q) begin
          state_d = S_RESET_ROOTS;
        end else if (req_valid) begin
          state_d = S_WRITE;
        end
      end
      S_RESET_ROOTS: begin
        state_d   = S_IDLE;
        pending_d = pending_q | new_block;
        // The window only moves when the resident context sits on a half boundary.
        if ((ctx_q == CTX_ZERO) || (ctx_q == CTX_HALF)) begin
          if (!not_first_q) begin
            min_d       = CTX_HALF;
            max_d       = CTX_LAST;
            not_first_d = 1'b1;
          end else if (!full_range_q) begin
            min_d        = CTX_ZERO;
            max_d        = CTX_LAST;
            full_range_d = 1'b1;
          end else if (ctx_q == CTX_ZERO) begin
            min_d        = CTX_HALF;
            max_d        = CTX_LAST;
            full_range_d = 1'b0;
          end else begin
            min_d        = CTX_ZERO;
            max_d        = CTX_HALF_M1;
            full_range_d = 1'b0;
          end
        end
      end
      S_WRITE: begin
        state_d   = S_SETTLE;
        pending_d = pending_q | new_block;
        if (!dns_q) begin
          if (NUM_CONTEXTS == 2) begin
            ctx_d = ctx_q ^ CTX_ONE;
          end else if (ctx_q < max_q) begin
            ctx_d = ctx_q + CTX_ONE;
          end else begin
            ctx_d = min_q;
          end
        end
      end
      S_SETTLE: begin
        state_d   = S_IDLE;
        pending_d = pending_q | new_block;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    stage_d = STAGE_IDLE;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_RESET_ROOTS: stage_d = STAGE_RESET_ROOTS;
      S_WRITE:       stage_d = STAGE_WRITE_TO_MEM;
      default:       stage_d = STAGE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_support_context_scheduler.sv
// Directed bench for support_context_scheduler: N=4 instance for the main sequences,
// N=2 instance for the toggle behaviour.
module tb_support_context_scheduler;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RR    = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic       clk;
  logic       reset;
  logic       new_block, req_valid, req_local;
  logic       req_ready, do_not_store, busy;
  logic [1:0] stage_out;
  logic [1:0] active_context, context_min, context_max;

  logic       n2_new_block, n2_req_valid, n2_req_local;
  logic       n2_req_ready, n2_do_not_store, n2_busy;
  logic [1:0] n2_stage_out;
  logic [0:0] n2_active_context, n2_context_min, n2_context_max;

  int errors = 0;
  int checks = 0;

  support_context_scheduler #(.NUM_CONTEXTS(4)) dut4 (
    .clk(clk), .reset(reset), .new_block(new_block), .req_valid(req_valid),
    .req_local(req_local), .req_ready(req_ready), .stage_out(stage_out),
    .do_not_store(do_not_store), .active_context(active_context),
    .context_min(context_min), .context_max(context_max), .busy(busy)
  );

  support_context_scheduler #(.NUM_CONTEXTS(2)) dut2 (
    .clk(clk), .reset(reset), .new_block(n2_new_block), .req_valid(n2_req_valid),
    .req_local(n2_req_local), .req_ready(n2_req_ready), .stage_out(n2_stage_out),
    .do_not_store(n2_do_not_store), .active_context(n2_active_context),
    .context_min(n2_context_min), .context_max(n2_context_max), .busy(n2_busy)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_window(input string tag, input logic [31:0] mn, input logic [31:0] mx);
    chk({tag, "_min"}, 32'(context_min), mn);
    chk({tag, "_max"}, 32'(context_max), mx);
  endtask

  initial begin
    int ctx_tab[4];
    ctx_tab = '{1, 2, 3, 0};
    reset = 1'b1;
    new_block = 0; req_valid = 0; req_local = 0;
    n2_new_block = 0; n2_req_valid = 0; n2_req_local = 0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // 1. reset state
    chk("rst_stage", 32'(stage_out), ST_IDLE);
    chk("rst_ctx", 32'(active_context), 0);
    chk_window("rst_win", 0, 1);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dns", 32'(do_not_store), 0);

    // 2. two root resets with ctx=0
    new_block = 1;
    #1;
    chk("nb_ready_low", 32'(req_ready), 0);
    tick();
    new_block = 0;
    chk("nb1_stage", 32'(stage_out), ST_RR);
    chk("nb1_busy", 32'(busy), 1);
    tick();
    chk("nb1_stage_end", 32'(stage_out), ST_IDLE);
    chk_window("nb1_win", 2, 3);
    new_block = 1;
    tick();
    new_block = 0;
    chk("nb2_stage", 32'(stage_out), ST_RR);
    tick();
    chk_window("nb2_win", 0, 3);

    // 3. four stored switches wrap across [0,3]
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_local = 0;
      #1;
      chk("sw_ready", 32'(req_ready), 1);
      tick();
      req_valid = 0;
      chk("sw_write", 32'(stage_out), ST_WRITE);
      chk("sw_ready_w", 32'(req_ready), 0);
      tick();
      chk("sw_settle", 32'(stage_out), ST_IDLE);
      chk("sw_busy_s", 32'(busy), 1);
      chk("sw_ctx", 32'(active_context), 32'(ctx_tab[i]));
      chk("sw_ready_s", 32'(req_ready), 0);
      tick();
      chk("sw_ready_back", 32'(req_ready), 1);
    end

    // 4. local switch keeps context, sets do_not_store
    req_valid = 1; req_local = 1;
    tick();
    req_valid = 0; req_local = 0;
    chk("loc_write", 32'(stage_out), ST_WRITE);
    chk("loc_dns", 32'(do_not_store), 1);
    tick();
    chk("loc_ctx", 32'(active_context), 0);
    tick();
    chk("loc_dns_hold", 32'(do_not_store), 1);
    req_valid = 1;
    tick();
    req_valid = 0;
    chk("nl_dns", 32'(do_not_store), 0);
    tick();
    chk("nl_ctx", 32'(active_context), 1);
    tick();

    // 5. new_block wins over a simultaneous request; ctx=1 leaves window alone
    new_block = 1; req_valid = 1;
    #1;
    chk("pri_ready", 32'(req_ready), 0);
    tick();
    new_block = 0;
    chk("pri_rr", 32'(stage_out), ST_RR);
    tick();
    chk("pri_idle", 32'(stage_out), ST_IDLE);
    chk_window("pri_win", 0, 3);
    chk("pri_ready_after", 32'(req_ready), 1);
    tick();
    req_valid = 0;
    chk("pri_write", 32'(stage_out), ST_WRITE);
    tick();
    chk("pri_ctx", 32'(active_context), 2);
    tick();

    // new_block while busy is held pending and serviced before the next request
    req_valid = 1;
    tick();
    req_valid = 0;
    new_block = 1;
    tick();
    new_block = 0;
    chk("pend_ctx", 32'(active_context), 3);
    req_valid = 1;
    tick();
    chk("pend_busy", 32'(busy), 0);
    chk("pend_ready", 32'(req_ready), 0);
    tick();
    chk("pend_rr", 32'(stage_out), ST_RR);
    tick();
    chk_window("pend_win", 0, 3);
    tick();
    req_valid = 0;
    chk("pend_write", 32'(stage_out), ST_WRITE);
    tick();
    chk("pend_wrap", 32'(active_context), 0);
    tick();

    // full_range with ctx=0 narrows to upper half
    new_block = 1;
    tick();
    new_block = 0;
    tick();
    chk_window("fr_win", 2, 3);

    // 6. reset in the middle of S_WRITE
    req_valid = 1;
    tick();
    req_valid = 0;
    chk("mid_write", 32'(stage_out), ST_WRITE);
    #2;
    reset = 1;
    #1;
    chk("mr_stage", 32'(stage_out), ST_IDLE);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_ready", 32'(req_ready), 1);
    chk("mr_ctx", 32'(active_context), 0);
    chk_window("mr_win", 0, 1);
    #1;
    reset = 0;
    tick();
    chk("mr_stay_idle", 32'(stage_out), ST_IDLE);

    // N=2 instance toggles between contexts 0 and 1
    chk("n2_rst_ctx", 32'(n2_active_context), 0);
    chk("n2_rst_max", 32'(n2_context_max), 0);
    n2_req_valid = 1;
    tick();
    n2_req_valid = 0;
    chk("n2_write", 32'(n2_stage_out), ST_WRITE);
    tick();
    chk("n2_ctx1", 32'(n2_active_context), 1);
    tick();
    n2_req_valid = 1;
    tick();
    n2_req_valid = 0;
    tick();
    chk("n2_ctx0", 32'(n2_active_context), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
